// File: rtl/dino_pkg.sv
// Shared types and widths for the dino game blocks.
package dino_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int BCD_W = 4;
  localparam int LVL_W = 3;
endpackage

// File: rtl/game_scheduler_bcd_counter.sv
// Multi-digit BCD counter: synchronous clear, increment enable, saturates at all-9s.
module bcd_counter
  import dino_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [DIGITS*BCD_W-1:0]   value_o,
  output logic                      max_flag_o
);
  logic [DIGITS-1:0][BCD_W-1:0] cnt_q, cnt_d;
  logic                         carry;

  always_comb begin
    max_flag_o = 1'b1;
    for (int i = 0; i < DIGITS; i++) max_flag_o &= (cnt_q[i] == 4'd9);
  end

  // Ripple the carry digit by digit; an increment at all-9s is dropped.
  always_comb begin
    cnt_d = cnt_q;
    carry = inc_i & ~max_flag_o;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_d[i] = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;
endmodule

// File: rtl/game_scheduler.sv
// Dino game sequencer: IDLE/RUN/OVER lifecycle, BCD score, speed level, restart strobe.
// Optional high-score tracking is enabled by defining GAME_HISCORE_EN.
module game_scheduler
  import dino_pkg::*;
#(
  parameter int SCORE_DIGITS     = 4,
  parameter int TICKS_PER_POINT  = 6,
  parameter int POINTS_PER_LEVEL = 100,
  parameter int MAX_LEVEL        = 7,
  parameter int OVER_HOLD_TICKS  = 60
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          game_tick,
  input  logic                          start_req,
  input  logic                          collision,
  output logic                          run_en,
  output logic                          restart,
  output logic                          game_over,
  output logic [1:0]                    state,
  output logic [LVL_W-1:0]              speed_level,
  output logic [SCORE_DIGITS*BCD_W-1:0] score,
  output logic [SCORE_DIGITS*BCD_W-1:0] hi_score
);
  localparam int TW = (TICKS_PER_POINT > 1)  ? $clog2(TICKS_PER_POINT)     : 1;
  localparam int PW = (POINTS_PER_LEVEL > 1) ? $clog2(POINTS_PER_LEVEL)    : 1;
  localparam int HW = (OVER_HOLD_TICKS > 0)  ? $clog2(OVER_HOLD_TICKS + 1) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_POINT - 1);
  localparam logic [PW-1:0]    PT_LAST   = PW'(POINTS_PER_LEVEL - 1);
  localparam logic [HW-1:0]    HOLD_MAX  = HW'(OVER_HOLD_TICKS);
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LEVEL);

  state_t           state_q;
  logic             run_en_q, restart_q, game_over_q;
  logic [TW-1:0]    tick_q;
  logic [PW-1:0]    pt_q;
  logic [HW-1:0]    hold_q;
  logic [LVL_W-1:0] level_q;
  logic             hold_done, start_acc, point_inc, score_max;

  // hold_q is the pre-tick count, so a same-cycle tick cannot unlock a start.
  assign hold_done = (hold_q == HOLD_MAX);
  assign start_acc = start_req && ((state_q == IDLE) || ((state_q == OVER) && hold_done));
  assign point_inc = (state_q == RUN) && game_tick && !collision && (tick_q == TICK_LAST);

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_acc),
    .inc_i      (point_inc),
    .value_o    (score),
    .max_flag_o (score_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_en_q    <= 1'b0;
      restart_q   <= 1'b0;
      game_over_q <= 1'b0;
      tick_q      <= '0;
      pt_q        <= '0;
      hold_q      <= '0;
      level_q     <= '0;
    end else begin
      restart_q <= 1'b0;
      if (start_acc) begin
        state_q     <= RUN;
        run_en_q    <= 1'b1;
        restart_q   <= 1'b1;
        game_over_q <= 1'b0;
        tick_q      <= '0;
        pt_q        <= '0;
        hold_q      <= '0;
        level_q     <= '0;
      end else begin
        case (state_q)
          RUN: if (game_tick) begin
            if (collision) begin
              state_q     <= OVER;
              run_en_q    <= 1'b0;
              game_over_q <= 1'b1;
            end else begin
              tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
              if (point_inc && !score_max) begin
                if (pt_q == PT_LAST) begin
                  pt_q <= '0;
                  if (level_q != LVL_MAX) level_q <= level_q + 1'b1;
                end else begin
                  pt_q <= pt_q + 1'b1;
                end
              end
            end
          end
          OVER: if (game_tick && !hold_done) hold_q <= hold_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_DIGITS*BCD_W-1:0] hi_q;

  // Packed BCD orders the same as its decimal value, so a plain compare works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hi_q <= '0;
    else if ((state_q == RUN) && game_tick && collision && (score > hi_q)) hi_q <= score;
  end
  assign hi_score = hi_q;
`else
  assign hi_score = '0;
`endif

  assign state       = state_q;
  assign run_en      = run_en_q;
  assign restart     = restart_q;
  assign game_over   = game_over_q;
  assign speed_level = level_q;
endmodule

// File: tb/tb_game_scheduler.sv
// Directed bench for game_scheduler: vector table plus long-run scoring, lockout and reset sequences.
module tb_game_scheduler;
`ifdef GAME_HISCORE_EN
  localparam bit HI_ON = 1'b1;
`else
  localparam bit HI_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, game_tick, start_req, collision;
  logic        run_en, restart, game_over;
  logic [1:0]  state;
  logic [2:0]  speed_level;
  logic [15:0] score, hi_score;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  game_scheduler #(
    .SCORE_DIGITS(4), .TICKS_PER_POINT(2), .POINTS_PER_LEVEL(100),
    .MAX_LEVEL(7), .OVER_HOLD_TICKS(4)
  ) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick), .start_req(start_req),
    .collision(collision), .run_en(run_en), .restart(restart),
    .game_over(game_over), .state(state), .speed_level(speed_level),
    .score(score), .hi_score(hi_score)
  );

  typedef struct {
    logic        tick, start, coll;
    logic [1:0]  st;
    logic        rs, run, ov;
    logic [15:0] sc;
    logic [2:0]  lvl;
    logic [15:0] hi;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic t, s, c, input logic [1:0] st,
                              input logic rs, run, ov, input logic [15:0] sc,
                              input logic [2:0] lvl, input logic [15:0] hi);
    vec_t v;
    v.tick = t; v.start = s; v.coll = c; v.st = st; v.rs = rs; v.run = run;
    v.ov = ov; v.sc = sc; v.lvl = lvl; v.hi = hi;
    return v;
  endfunction

  function automatic logic [15:0] hx(input logic [15:0] v);
    return HI_ON ? v : 16'h0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic rs, run, ov,
                         input logic [15:0] sc, input logic [2:0] lvl, input logic [15:0] hi);
    chk({tag, ".state"},     32'(state),       32'(st));
    chk({tag, ".restart"},   32'(restart),     32'(rs));
    chk({tag, ".run_en"},    32'(run_en),      32'(run));
    chk({tag, ".game_over"}, 32'(game_over),   32'(ov));
    chk({tag, ".score"},     32'(score),       32'(sc));
    chk({tag, ".level"},     32'(speed_level), 32'(lvl));
    chk({tag, ".hi_score"},  32'(hi_score),    32'(hi));
  endtask

  task automatic cyc(input logic t, s, c);
    @(negedge clk);
    game_tick = t; start_req = s; collision = c;
    @(posedge clk);
    #1;
    game_tick = 1'b0; start_req = 1'b0; collision = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; game_tick = 1'b0; start_req = 1'b0; collision = 1'b0;
    //           tick s  c   st  rs run ov  score     lvl  hi
    tbl[0]  = mk(0,  0, 0, 2'd0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000); // idle
    tbl[1]  = mk(0,  1, 0, 2'd1, 1, 1, 0, 16'h0000, 3'd0, 16'h0000); // start
    tbl[2]  = mk(0,  0, 0, 2'd1, 0, 1, 0, 16'h0000, 3'd0, 16'h0000); // one-cycle restart
    tbl[3]  = mk(1,  0, 0, 2'd1, 0, 1, 0, 16'h0000, 3'd0, 16'h0000);
    tbl[4]  = mk(1,  0, 0, 2'd1, 0, 1, 0, 16'h0001, 3'd0, 16'h0000); // point
    tbl[5]  = mk(0,  1, 0, 2'd1, 0, 1, 0, 16'h0001, 3'd0, 16'h0000); // jump ignored
    tbl[6]  = mk(1,  0, 0, 2'd1, 0, 1, 0, 16'h0001, 3'd0, 16'h0000);
    tbl[7]  = mk(1,  0, 1, 2'd2, 0, 0, 1, 16'h0001, 3'd0, hx(16'h0001)); // collision on wrap
    tbl[8]  = mk(1,  0, 0, 2'd2, 0, 0, 1, 16'h0001, 3'd0, hx(16'h0001));
    tbl[9]  = mk(1,  0, 0, 2'd2, 0, 0, 1, 16'h0001, 3'd0, hx(16'h0001));
    tbl[10] = mk(1,  0, 0, 2'd2, 0, 0, 1, 16'h0001, 3'd0, hx(16'h0001));
    tbl[11] = mk(0,  1, 0, 2'd2, 0, 0, 1, 16'h0001, 3'd0, hx(16'h0001)); // locked out
    tbl[12] = mk(1,  1, 0, 2'd2, 0, 0, 1, 16'h0001, 3'd0, hx(16'h0001)); // pre-tick count used
    tbl[13] = mk(0,  1, 0, 2'd1, 1, 1, 0, 16'h0000, 3'd0, hx(16'h0001)); // restart accepted
    tbl[14] = mk(1,  0, 0, 2'd1, 0, 1, 0, 16'h0000, 3'd0, hx(16'h0001));
    tbl[15] = mk(1,  0, 0, 2'd1, 0, 1, 0, 16'h0001, 3'd0, hx(16'h0001));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 0, 0, 0, 16'h0, 3'd0, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].tick, tbl[i].start, tbl[i].coll);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].rs, tbl[i].run, tbl[i].ov,
              tbl[i].sc, tbl[i].lvl, tbl[i].hi);
    end

    // Score 0x41, then collide on the wrap tick.
    ticks(80);
    chk_all("pre41", 2'd1, 0, 1, 0, 16'h0041, 3'd0, hx(16'h0001));
    ticks(1);
    cyc(1'b1, 1'b0, 1'b1);
    chk_all("coll41", 2'd2, 0, 0, 1, 16'h0041, 3'd0, hx(16'h0041));
    ticks(4);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("restart2", 2'd1, 1, 1, 0, 16'h0000, 3'd0, hx(16'h0041));

    // Level boundary and saturation.
    ticks(198);
    chk_all("pts99", 2'd1, 0, 1, 0, 16'h0099, 3'd0, hx(16'h0041));
    ticks(2);
    chk_all("pts100", 2'd1, 0, 1, 0, 16'h0100, 3'd1, hx(16'h0041));
    ticks(3000);
    chk_all("pts1600", 2'd1, 0, 1, 0, 16'h1600, 3'd7, hx(16'h0041));
    ticks(16798);
    chk_all("pts9999", 2'd1, 0, 1, 0, 16'h9999, 3'd7, hx(16'h0041));
    ticks(6);
    chk_all("sat9999", 2'd1, 0, 1, 0, 16'h9999, 3'd7, hx(16'h0041));
    cyc(1'b1, 1'b0, 1'b1);
    chk_all("coll9999", 2'd2, 0, 0, 1, 16'h9999, 3'd7, hx(16'h9999));

    // Mid-run asynchronous reset.
    ticks(4);
    cyc(1'b0, 1'b1, 1'b0);
    ticks(246);
    chk_all("pts123", 2'd1, 0, 1, 0, 16'h0123, 3'd1, hx(16'h9999));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("post_rst", 2'd0, 0, 0, 0, 16'h0000, 3'd0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/game_scheduler.md
# game_scheduler

Top-level game sequencer for the dino game. It owns the run/over/idle lifecycle, gates obstacle and physics advancement, and issues a one-cycle restart strobe that clears dino and obstacle state. It keeps the BCD score and schedules the speed level that the obstacle generator uses. It sits between the input handler and collision detector (inputs) and the obstacle generator, game FSM and graphics engine (outputs), and runs entirely in the `clk` domain.

## Interface
- `SCORE_DIGITS`, default 4: number of BCD score digits.
- `TICKS_PER_POINT`, default 6: game ticks in RUN per score point; must be ≥ 1.
- `POINTS_PER_LEVEL`, default 100: points per speed-level step; must be ≥ 1.
- `MAX_LEVEL`, default 7: saturation value of `speed_level`; must be ≤ 7.
- `OVER_HOLD_TICKS`, default 60: game ticks in OVER before a restart is accepted.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `game_tick` in 1: single-cycle game-rate strobe.
- `start_req` in 1: single-cycle debounced button pulse.
- `collision` in 1: level signal, sampled only on `game_tick`.
- `run_en` out 1: high while in RUN; qualifies obstacle and physics updates.
- `restart` out 1: one-cycle pulse that clears dino and obstacle state.
- `game_over` out 1: high while in OVER.
- `state` out 2: IDLE=0, RUN=1, OVER=2.
- `speed_level` out 3: current level, 0..`MAX_LEVEL`.
- `score` out 4·`SCORE_DIGITS`: packed BCD, least-significant digit in bits [3:0].
- `hi_score` out 4·`SCORE_DIGITS`: packed BCD best score.

## Operation
- **Reset values:**
  - `state` = IDLE.
  - `run_en`, `restart`, `game_over` = 0.
  - `score`, `hi_score`, `speed_level` = 0.
  - Internal tick, point and hold counters = 0.
- **IDLE:**
  - `start_req` → RUN.
  - On that transition: pulse `restart`; clear `score`, `speed_level` and all counters.
- **RUN:**
  - Updates happen only on a `game_tick` cycle.
  - If `collision` = 1: go to OVER. No score update on that tick.
  - Otherwise: increment the tick counter. When it reaches `TICKS_PER_POINT`−1, wrap it to 0 and add 1 to `score`.
  - `start_req` is ignored (it is a jump).
- **Score:**
  - BCD increment with per-digit carry.
  - At all-9s (9999), `score` saturates: no wrap, and the point counter does not advance.
- **Level:**
  - A binary point counter runs 0..`POINTS_PER_LEVEL`−1.
  - On wrap, `speed_level` increments, saturating at `MAX_LEVEL`.
- **OVER:**
  - The hold counter increments on each `game_tick`, saturating at `OVER_HOLD_TICKS`.
  - `start_req` while the hold counter < `OVER_HOLD_TICKS`: ignored.
  - `start_req` once the hold counter = `OVER_HOLD_TICKS`: go to RUN, with the same clearing and `restart` pulse as the IDLE exit.
- **Simultaneous events:**
  - `collision` together with a point-wrap tick: collision wins and the score is unchanged.
  - `start_req` and `game_tick` in the same cycle in OVER: the transition uses the hold count from before that tick.
- `rst` asserted in any state forces the reset values immediately (asynchronously), including `hi_score`.

## Timing
- All outputs are registered. Each responds in the cycle after the input edge that causes it.
- `restart` is high for exactly one cycle: the first cycle with `state` = RUN.
- `run_en` rises in that same cycle.
- `game_over` and `state` change together.
- The `score` update is visible one cycle after the qualifying `game_tick`.
- `speed_level` updates in the same cycle as the `score` increment that completes a level.

## Configuration
- `GAME_HISCORE_EN` defined:
  - On the RUN→OVER transition, `hi_score` ← `score` if `score` > `hi_score`.
  - The comparison is an unsigned compare of the packed BCD values.
  - `hi_score` is visible in the first OVER cycle.
- `GAME_HISCORE_EN` undefined: `hi_score` is tied to 0 and no register is inferred.

## Structure
- Shared package `dino_pkg` holds:
  - the state encoding as an enumerated typedef (IDLE/RUN/OVER);
  - `BCD_W` = 4;
  - the level width constant of 3.
- Sub-module `bcd_counter`:
  - parameterised digit count;
  - synchronous clear, increment enable, saturate-at-max;
  - outputs `max_flag`.
- All other logic stays flat in `game_scheduler`.

## Test plan
All scenarios use the default parameters with `TICKS_PER_POINT`=2 and `OVER_HOLD_TICKS`=4.

1. **Reset and start:** release `rst`, pulse `start_req` → next cycle `state`=1, `restart`=1 for one cycle, `run_en`=1, `score`=0.
2. **Scoring:** 2 ticks → `score`=0x0001. 200 ticks → `score`=0x0100 and `speed_level`=1. Continue to 1600 points → `speed_level` saturates at 7.
3. **Collision priority:** `collision` on a point-wrap tick at `score`=0x0041 → `state`=2, `game_over`=1, `score` stays 0x0041, and `hi_score`=0x0041 (macro on).
4. **Restart lockout:** in OVER, `start_req` after 3 ticks → ignored. After the 4th tick, `start_req` → RUN, `restart` pulse, `score`=0, `speed_level`=0, `hi_score` kept.
5. **Saturation:** preload the run to `score`=0x9999 → further ticks leave it at 0x9999.
6. **Mid-run reset:** assert `rst` in RUN with `score`=0x0123 → all outputs zero immediately, before the next `clk` edge.
